vi_rst_seq: RTL and testbench
=============================

Name: vi_rst_seq

Overview:
- Multi-domain reset release sequencer.
- Sits downstream of the per-clock reset synchronizer and releases NUM_STAGES active-low resets strictly in order (e.g. PLL, transceiver, core, MAC).
- Stage k+1 is released only after stage k is released, its ready/ack is seen, and a settle hold expires.
- Any loss of an already-acknowledged ready, or a software request, restarts the whole sequence.

Parameters:
- NUM_STAGES, 4, number of sequenced reset outputs; legal range 1..8.
- ASSERT_CYCLES, 16, cycles all outputs are held in reset before stage 0 is released; at least 1.
- HOLD_CYCLES, 32, settle cycles after a stage's ack before the next release or DONE; at least 1.
- ACK_TIMEOUT, 65535, WAIT_ACK cycle limit; used only with VI_RST_SEQ_TIMEOUT_EN.

Ports:
- iCLK  in  1  clock.
- iRST_N  in  1  reset; synchronous, active-low.
- iSW_RST  in  1  software re-sequence request; level, active-high.
- iSTAGE_ACK  in  NUM_STAGES  per-stage ready, level; bit k belongs to stage k.
- oRST_N  out  NUM_STAGES  stage resets, active-low, registered; bit 0 is released first.
- oSTAGE  out  $clog2(NUM_STAGES)+1  index of the stage currently being processed.
- oBUSY  out  1  high whenever the FSM is not in DONE.
- oDONE  out  1  all stages released and acknowledged.
- oRESTART  out  1  one-cycle pulse when an ack loss forces a restart.
- oTIMEOUT  out  1  sticky ack-timeout flag.

Behaviour:
- All outputs are registered.
- Reset (iRST_N=0 sampled at an edge):
  - state ASSERT, cnt=0, k=0, ack_mask=0.
  - oRST_N=0, oSTAGE=0, oBUSY=1, oDONE=0, oRESTART=0, oTIMEOUT=0.
- ASSERT:
  - oRST_N all 0; cnt increments each cycle.
  - On the edge ending the ASSERT_CYCLES-th ASSERT cycle: oRST_N[0]=1, cnt=0, go to WAIT_ACK.
- WAIT_ACK(k):
  - When iSTAGE_ACK[k]=1: set ack_mask[k], cnt=0, go to HOLD on that edge.
- HOLD(k):
  - On the edge ending the HOLD_CYCLES-th HOLD cycle:
    - if k=NUM_STAGES-1: go to DONE (oDONE=1, oBUSY=0);
    - else k=k+1 and oRST_N[k]=1 on the same edge, go to WAIT_ACK.
  - Release-to-release spacing with ack already high is HOLD_CYCLES+1 cycles.
- DONE: outputs are stable; remain here until a restart cause occurs.
- Ack loss:
  - Condition: (ack_mask & ~iSTAGE_ACK)!=0 in WAIT_ACK, HOLD or DONE.
  - Next edge: state ASSERT, oRST_N all 0, ack_mask=0, k=0, cnt=0, oDONE=0, oBUSY=1.
  - oRESTART=1 for exactly one cycle.
- iSW_RST=1 in any state:
  - Same effect as ack loss, but oRESTART stays 0.
  - Holding iSW_RST high keeps the FSM in ASSERT with cnt=0.
  - Clears oTIMEOUT.
- Priority: iRST_N > iSW_RST > ack loss > timeout > normal counter transitions.
- A stage's ack that is high before its release is ignored until the WAIT_ACK(k) state is reached.
- cnt width is $clog2(max(ASSERT_CYCLES,HOLD_CYCLES,ACK_TIMEOUT)+1). cnt never wraps, because every terminal count forces a transition.
- NUM_STAGES=1: DONE follows HOLD(0) directly.

Optional Feature:
- Macro: VI_RST_SEQ_TIMEOUT_EN.
- Defined:
  - In WAIT_ACK, if ACK_TIMEOUT cycles elapse with no ack: oTIMEOUT=1 (sticky), then a full restart via ASSERT.
  - This retries indefinitely; oRESTART is not pulsed.
  - oTIMEOUT clears only on iRST_N or iSW_RST.
- Undefined:
  - WAIT_ACK waits forever; oTIMEOUT is tied 0; no timeout comparator is built.

Decomposition:
- Package vi_rst_seq_pkg holds:
  - state enum typedef (ASSERT, WAIT_ACK, HOLD, DONE);
  - a max-of-three width function used for cnt sizing.
- No sub-module: the single FSM plus shared counter is a natural single block. Instantiation next to the reset synchronizer is done at top level.

Test Plan:
- Common configuration: NUM_STAGES=3, ASSERT_CYCLES=16, HOLD_CYCLES=32.
- 1. Acks tied high, iRST_N rises -> oRST_N[0] rises at edge 16, [1] at 49, [2] at 82; oDONE=1 and oBUSY=0 at edge 115.
- 2. iSTAGE_ACK[1] asserted 100 cycles after oRST_N[1] rises -> HOLD begins the edge after the ack; oRST_N[2] rises 33 cycles after the ack; oSTAGE=1 during the wait.
- 3. iSTAGE_ACK[0] drops for 1 cycle in DONE -> next edge: oRST_N=000, oDONE=0, oRESTART one-cycle pulse; the full timing of test 1 then repeats.
- 4. iSW_RST pulsed during HOLD(1) -> next edge: all resets asserted, oRESTART=0; re-sequence matches test 1 timing counted from the pulse's deassertion.
- 5. Macro defined, ACK_TIMEOUT=64, iSTAGE_ACK[2] held 0 -> after 64 WAIT_ACK cycles oTIMEOUT=1 and the FSM restarts.
  - Without the macro: the FSM stays in WAIT_ACK, oTIMEOUT=0.
- 6. iRST_N driven low mid-edge-period during HOLD(0) -> outputs unchanged until the next iCLK edge, then exactly the reset values.

Source files
------------

// File: rtl/vi_rst_seq_pkg.sv
// Shared state type and counter-sizing helper for the vi_rst_seq reset-release sequencer.
package vi_rst_seq_pkg;

   typedef enum logic [1:0] {
      ASSERT   = 2'd0,
      WAIT_ACK = 2'd1,
      HOLD     = 2'd2,
      DONE     = 2'd3
   } seq_state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/vi_rst_seq.sv
// Ordered multi-domain reset release: stage k+1 leaves reset only after stage k is acked and settled.
// Optional ack timeout with automatic retry is built when VI_RST_SEQ_TIMEOUT_EN is defined.
module vi_rst_seq
   import vi_rst_seq_pkg::*;
#(
   parameter int NUM_STAGES    = 4,
   parameter int ASSERT_CYCLES = 16,
   parameter int HOLD_CYCLES   = 32,
   parameter int ACK_TIMEOUT   = 65535
) (
   input  logic                            iCLK,
   input  logic                            iRST_N,
   input  logic                            iSW_RST,
   input  logic [NUM_STAGES-1:0]           iSTAGE_ACK,
   output logic [NUM_STAGES-1:0]           oRST_N,
   output logic [$clog2(NUM_STAGES):0]     oSTAGE,
   output logic                            oBUSY,
   output logic                            oDONE,
   output logic                            oRESTART,
   output logic                            oTIMEOUT
);

   localparam int STG_W = $clog2(NUM_STAGES) + 1;
   localparam int CNT_W = $clog2(max3(ASSERT_CYCLES, HOLD_CYCLES, ACK_TIMEOUT) + 1);

   seq_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [STG_W-1:0]      stage_q, stage_d;
   logic [NUM_STAGES-1:0] mask_q, mask_d;
   logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
   logic                  busy_q, done_q;
   logic                  restart_q, restart_d;
   logic                  ack_cur;
   logic                  ack_lost;
`ifdef VI_RST_SEQ_TIMEOUT_EN
   logic                  timeout_q, timeout_d;
`endif

   // Ack of the stage currently being processed.
   always_comb begin
      ack_cur = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++)
         if (stage_q == STG_W'(i)) ack_cur = iSTAGE_ACK[i];
   end

   assign ack_lost = |(mask_q & ~iSTAGE_ACK);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stage_d   = stage_q;
      mask_d    = mask_q;
      restart_d = 1'b0;
`ifdef VI_RST_SEQ_TIMEOUT_EN
      timeout_d = timeout_q;
`endif
      if (iSW_RST || ack_lost) begin
         state_d   = ASSERT;
         cnt_d     = '0;
         stage_d   = '0;
         mask_d    = '0;
         restart_d = !iSW_RST;
`ifdef VI_RST_SEQ_TIMEOUT_EN
         if (iSW_RST) timeout_d = 1'b0;
`endif
      end else begin
         unique case (state_q)
            ASSERT: begin
               if (cnt_q == CNT_W'(ASSERT_CYCLES - 1)) begin
                  state_d = WAIT_ACK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            WAIT_ACK: begin
               if (ack_cur) begin
                  for (int i = 0; i < NUM_STAGES; i++)
                     if (stage_q == STG_W'(i)) mask_d[i] = 1'b1;
                  state_d = HOLD;
                  cnt_d   = '0;
               end
`ifdef VI_RST_SEQ_TIMEOUT_EN
               else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                  timeout_d = 1'b1;
                  state_d   = ASSERT;
                  cnt_d     = '0;
                  stage_d   = '0;
                  mask_d    = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`endif
            end
            HOLD: begin
               if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                  cnt_d = '0;
                  if (stage_q == STG_W'(NUM_STAGES - 1)) begin
                     state_d = DONE;
                  end else begin
                     stage_d = stage_q + STG_W'(1);
                     state_d = WAIT_ACK;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            DONE:    state_d = DONE;
            default: state_d = ASSERT;
         endcase
      end

      // Released stages form a thermometer code up to and including the active stage.
      for (int i = 0; i < NUM_STAGES; i++)
         rst_n_d[i] = (state_d != ASSERT) && (STG_W'(i) <= stage_d);
   end

   // NOTE: reset is synchronous here: iRST_N is only sampled at the clock edge, never in the sensitivity list.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q   <= ASSERT;
         cnt_q     <= '0;
         stage_q   <= '0;
         mask_q    <= '0;
         rst_n_q   <= '0;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
         restart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         stage_q   <= stage_d;
         mask_q    <= mask_d;
         rst_n_q   <= rst_n_d;
         busy_q    <= (state_d != DONE);
         done_q    <= (state_d == DONE);
         restart_q <= restart_d;
      end
   end

`ifdef VI_RST_SEQ_TIMEOUT_EN
   always_ff @(posedge iCLK) begin
      if (!iRST_N) timeout_q <= 1'b0;
      else         timeout_q <= timeout_d;
   end
   assign oTIMEOUT = timeout_q;
`else
   assign oTIMEOUT = 1'b0;
`endif

   assign oRST_N   = rst_n_q;
   assign oSTAGE   = stage_q;
   assign oBUSY    = busy_q;
   assign oDONE    = done_q;
   assign oRESTART = restart_q;

endmodule

// File: tb/tb_vi_rst_seq.sv
// Self-checking bench for vi_rst_seq: timing tables, directed corner sequences, and random
// stimulus compared every cycle against a counting model of released/acked stages.
module tb_vi_rst_seq;

   localparam int N = 3;
   localparam int A = 16;
   localparam int H = 32;
   localparam int T = 64;
   localparam int SW = $clog2(N) + 1;

   logic          iCLK = 1'b0;
   logic          iRST_N;
   logic          iSW_RST;
   logic [N-1:0]  iSTAGE_ACK;
   logic [N-1:0]  oRST_N;
   logic [SW-1:0] oSTAGE;
   logic          oBUSY, oDONE, oRESTART, oTIMEOUT;

   always #5 iCLK = ~iCLK;

   vi_rst_seq #(
      .NUM_STAGES   (N),
      .ASSERT_CYCLES(A),
      .HOLD_CYCLES  (H),
      .ACK_TIMEOUT  (T)
   ) dut (
      .iCLK      (iCLK),
      .iRST_N    (iRST_N),
      .iSW_RST   (iSW_RST),
      .iSTAGE_ACK(iSTAGE_ACK),
      .oRST_N    (oRST_N),
      .oSTAGE    (oSTAGE),
      .oBUSY     (oBUSY),
      .oDONE     (oDONE),
      .oRESTART  (oRESTART),
      .oTIMEOUT  (oTIMEOUT)
   );

   int n_pass  = 0;
   int n_total = 0;
   int edge_n  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: how many stages are released / acknowledged, plus a countdown.
   int m_rel, m_ack, m_left, m_twait;
   bit m_restart, m_timeout;

   function automatic bit m_lost();
      for (int i = 0; i < m_ack; i++)
         if (!iSTAGE_ACK[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_restart_seq();
      m_rel = 0; m_ack = 0; m_left = A; m_twait = 0;
   endtask

   task automatic model_step();
      m_restart = 1'b0;
      if (!iRST_N) begin
         m_restart_seq();
         m_timeout = 1'b0;
      end else if (iSW_RST) begin
         m_restart_seq();
         m_timeout = 1'b0;
      end else if (m_lost()) begin
         m_restart_seq();
         m_restart = 1'b1;
      end else if (m_rel == 0) begin
         m_left--;
         if (m_left == 0) begin m_rel = 1; m_twait = 0; end
      end else if (m_rel > m_ack) begin
         if (iSTAGE_ACK[m_ack]) begin
            m_ack++;
            m_left = H;
         end
`ifdef VI_RST_SEQ_TIMEOUT_EN
         else if (m_twait + 1 == T) begin
            m_timeout = 1'b1;
            m_restart_seq();
         end
`endif
         else m_twait++;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && m_rel < N) begin m_rel++; m_twait = 0; end
      end
   endtask

   task automatic cycle();
      logic [N-1:0]  e_rst;
      logic [SW-1:0] e_stage;
      logic          e_done;
      @(posedge iCLK);
      model_step();
      edge_n++;
      #1;
      e_rst   = N'((1 << m_rel) - 1);
      e_stage = (m_rel == 0) ? '0 : SW'(m_rel - 1);
      e_done  = (m_ack == N) && (m_left == 0);
      check($sformatf("model@e%0d", edge_n),
            32'({oRST_N, oSTAGE, oBUSY, oDONE, oRESTART, oTIMEOUT}),
            32'({e_rst, e_stage, !e_done, e_done, m_restart, m_timeout}));
   endtask

   task automatic run_to(input int e);
      while (edge_n < e) cycle();
   endtask

   typedef struct {
      int            edge_no;
      logic [N-1:0]  ack;
      logic [N-1:0]  rst_n;
      logic [SW-1:0] stage;
      logic          busy;
      logic          done;
   } vec_t;

   vec_t tbl[10];

   task automatic run_table(input string tag);
      for (int i = 0; i < 10; i++) begin
         iSTAGE_ACK = tbl[i].ack;
         iSW_RST    = 1'b0;
         run_to(tbl[i].edge_no);
         check($sformatf("%s_rst_n@e%0d", tag, tbl[i].edge_no), 32'(oRST_N), 32'(tbl[i].rst_n));
         check($sformatf("%s_stage@e%0d", tag, tbl[i].edge_no), 32'(oSTAGE), 32'(tbl[i].stage));
         check($sformatf("%s_busy_done@e%0d", tag, tbl[i].edge_no),
               32'({oBUSY, oDONE}), 32'({tbl[i].busy, tbl[i].done}));
      end
   endtask

   task automatic sw_restart();
      iSW_RST = 1'b1;
      cycle();
      iSW_RST = 1'b0;
      edge_n  = 0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rst_n"},  32'(oRST_N),  32'(0));
      check({tag, "_stage"},  32'(oSTAGE),  32'(0));
      check({tag, "_busy"},   32'(oBUSY),   32'(1));
      check({tag, "_done"},   32'(oDONE),   32'(0));
      check({tag, "_restart"},32'(oRESTART),32'(0));
      check({tag, "_timeout"},32'(oTIMEOUT),32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{15,  3'b111, 3'b000, SW'(0), 1'b1, 1'b0};
      tbl[1] = '{16,  3'b111, 3'b001, SW'(0), 1'b1, 1'b0};
      tbl[2] = '{17,  3'b111, 3'b001, SW'(0), 1'b1, 1'b0};
      tbl[3] = '{48,  3'b111, 3'b001, SW'(0), 1'b1, 1'b0};
      tbl[4] = '{49,  3'b111, 3'b011, SW'(1), 1'b1, 1'b0};
      tbl[5] = '{81,  3'b111, 3'b011, SW'(1), 1'b1, 1'b0};
      tbl[6] = '{82,  3'b111, 3'b111, SW'(2), 1'b1, 1'b0};
      tbl[7] = '{114, 3'b111, 3'b111, SW'(2), 1'b1, 1'b0};
      tbl[8] = '{115, 3'b111, 3'b111, SW'(2), 1'b0, 1'b1};
      tbl[9] = '{120, 3'b111, 3'b111, SW'(2), 1'b0, 1'b1};

      iRST_N     = 1'b0;
      iSW_RST    = 1'b0;
      iSTAGE_ACK = '0;
      m_restart_seq();
      m_restart = 1'b0;
      m_timeout = 1'b0;
      repeat (3) cycle();
      check_reset_values("reset");

      // Release from reset with all acks already high: early acks must be ignored.
      iRST_N = 1'b1;
      edge_n = 0;
      run_table("seq");

      // Single-cycle ack loss in DONE forces a restart pulse, then identical timing.
      iSTAGE_ACK = 3'b110;
      cycle();
      check("loss_rst_n",   32'(oRST_N),   32'(0));
      check("loss_done",    32'(oDONE),    32'(0));
      check("loss_restart", 32'(oRESTART), 32'(1));
      iSTAGE_ACK = 3'b111;
      edge_n = 0;
      cycle();
      check("loss_restart_clear", 32'(oRESTART), 32'(0));
      run_table("reseq");

      // Software request during HOLD(1), held for several cycles.
      iSTAGE_ACK = 3'b111;
      sw_restart();
      run_to(60);
      check("hold1_stage", 32'(oSTAGE), 32'(1));
      iSW_RST = 1'b1;
      cycle();
      check("sw_rst_n",   32'(oRST_N),   32'(0));
      check("sw_restart", 32'(oRESTART), 32'(0));
      check("sw_busy",    32'(oBUSY),    32'(1));
      repeat (4) begin
         cycle();
         check("sw_held_rst_n", 32'(oRST_N), 32'(0));
      end
      iSW_RST = 1'b0;
      edge_n  = 0;
      run_table("swseq");

      // Late ack on stage 1.
      iSTAGE_ACK = 3'b101;
      sw_restart();
      run_to(49);
      check("late_rel1", 32'(oRST_N), 32'(3'b011));
      run_to(149);
      check("late_wait_stage", 32'(oSTAGE), 32'(1));
      check("late_wait_rst_n", 32'(oRST_N), 32'(3'b011));
      iSTAGE_ACK = 3'b111;
      run_to(181);
      check("late_pre_rel2", 32'(oRST_N), 32'(3'b011));
      run_to(182);
      check("late_rel2", 32'(oRST_N), 32'(3'b111));

      // Stage 2 never acknowledges.
      iSTAGE_ACK = 3'b011;
      sw_restart();
      run_to(145);
      check("to_pre_rst_n",   32'(oRST_N),   32'(3'b111));
      check("to_pre_timeout", 32'(oTIMEOUT), 32'(0));
      run_to(146);
`ifdef VI_RST_SEQ_TIMEOUT_EN
      check("to_timeout", 32'(oTIMEOUT), 32'(1));
      check("to_rst_n",   32'(oRST_N),   32'(0));
      check("to_restart", 32'(oRESTART), 32'(0));
      run_to(200);
      check("to_sticky", 32'(oTIMEOUT), 32'(1));
      iSW_RST = 1'b1;
      cycle();
      iSW_RST = 1'b0;
      check("to_sw_clear", 32'(oTIMEOUT), 32'(0));
`else
      check("to_timeout", 32'(oTIMEOUT), 32'(0));
      check("to_rst_n",   32'(oRST_N),   32'(3'b111));
      check("to_stage",   32'(oSTAGE),   32'(2));
      check("to_busy",    32'(oBUSY),    32'(1));
`endif

      // Reset asserted between edges during HOLD(0): takes effect only at the edge.
      iSTAGE_ACK = 3'b111;
      sw_restart();
      run_to(25);
      #3;
      iRST_N = 1'b0;
      #1;
      check("midrst_rst_n", 32'(oRST_N), 32'(3'b001));
      check("midrst_busy",  32'(oBUSY),  32'(1));
      cycle();
      check_reset_values("midrst");
      iRST_N = 1'b1;

      // Random traffic: sticky acks with rare drops, rare software and hardware resets.
      for (int c = 0; c < 4000; c++) begin
         iRST_N  = ($urandom_range(0, 999) != 0);
         iSW_RST = ($urandom_range(0, 299) == 0);
         for (int b = 0; b < N; b++) begin
            if (iSTAGE_ACK[b]) iSTAGE_ACK[b] = ($urandom_range(0, 399) != 0);
            else               iSTAGE_ACK[b] = ($urandom_range(0, 19) == 0);
         end
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
